ftdi_fb_writer: RTL and testbench

Receives the pixel byte stream from the FT232H in synchronous 245-FIFO mode and packs it into 20-bit pixels. Writes the pixels sequentially into the back framebuffer's write port. Runs entirely in the `clk_60` (FTDI) domain. When a whole frame has been written, it raises `full_ftdi` and stops reading until the framebuffer reports a buffer swap on `swapped_ftdi`.

---
 rtl/ftdi_fb_writer_if.sv | 34 +++
 rtl/ftdi_fb_writer.sv | 166 ++++++++++++++++
 tb/tb_ftdi_fb_writer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ftdi_fb_writer_if.sv
// ftdi_fb_writer_if
// Bundles the FT232H 245-FIFO bus and the framebuffer write port used by
// ftdi_fb_writer.
//   ftdi_data     8   FIFO read data (from FTDI)
//   ftdi_rxf_n    1   low = FIFO has data (from FTDI)
//   ftdi_oe_n     1   low = FTDI drives the bus (to FTDI)
//   ftdi_rd_n     1   low = read strobe (to FTDI)
//   wdata         20  pixel to the framebuffer
//   waddr         14  pixel index to the framebuffer
//   we            1   one-cycle write strobe
//   full_ftdi     1   frame complete, awaiting swap
//   swapped_ftdi  1   one-cycle pulse from the framebuffer: buffers swapped
// master = the writer, slave = FTDI chip plus framebuffer.
interface ftdi_fb_writer_if;
    logic [7:0]  ftdi_data;
    logic        ftdi_rxf_n;
    logic        ftdi_oe_n;
    logic        ftdi_rd_n;
    logic [19:0] wdata;
    logic [13:0] waddr;
    logic        we;
    logic        full_ftdi;
    logic        swapped_ftdi;

    modport master (
        input  ftdi_data, ftdi_rxf_n, swapped_ftdi,
        output ftdi_oe_n, ftdi_rd_n, wdata, waddr, we, full_ftdi
    );

    modport slave (
        output ftdi_data, ftdi_rxf_n, swapped_ftdi,
        input  ftdi_oe_n, ftdi_rd_n, wdata, waddr, we, full_ftdi
    );
endinterface

// File: rtl/ftdi_fb_writer.sv
// ftdi_fb_writer
// Reads the FT232H byte stream (synchronous 245-FIFO mode), packs every three
// bytes little-endian into a 20-bit pixel and writes pixels sequentially into
// the back framebuffer. After PIXELS pixels it raises full_ftdi and stops
// reading until swapped_ftdi reports a buffer swap.
//
// Ports:
//   clk_60  in   60 MHz FTDI clock, the only clock
//   rst     in   synchronous active-high reset
//   bus     ftdi_fb_writer_if.master (FTDI FIFO bus + framebuffer write port)
//
// Parameters:
//   PIXELS          pixels per frame, 1..16384
//   TIMEOUT_CYCLES  idle cycles before a partial frame is discarded
//                   (present only with FTDI_FB_TIMEOUT_EN)
//
// Optional feature: define FTDI_FB_TIMEOUT_EN to discard a partial frame
// after TIMEOUT_CYCLES cycles without an accepted byte.
module ftdi_fb_writer #(
    parameter int PIXELS = 16384
`ifdef FTDI_FB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 600000
`endif
) (
    input  logic             clk_60,
    input  logic             rst,
    ftdi_fb_writer_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_OE,
        S_READ,
        S_FULL
    } state_t;

    localparam logic [13:0] LAST_INDEX = 14'(PIXELS - 1);

    state_t      state_reg;
    logic [1:0]  phase_reg;
    logic [13:0] index_reg;
    logic [15:0] low_reg;      // bytes 0 and 1 of the pixel being assembled
    logic        oe_n_reg;
    logic        rd_n_reg;
    logic        we_reg;
    logic        full_reg;
    logic [19:0] wdata_reg;
    logic [13:0] waddr_reg;

    logic accept;
    logic timeout;

    // rd_n is low exactly in READ, so a low rxf_n there means the FTDI has
    // presented a valid byte for this edge.
    assign accept = (state_reg == S_READ) && !bus.ftdi_rxf_n;

`ifdef FTDI_FB_TIMEOUT_EN
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    logic [19:0] idle_cnt_reg;
    logic        partial;
    logic        idle_active;

    assign partial     = (phase_reg != 2'd0) || (index_reg != 14'd0);
    assign idle_active = !accept && partial && (state_reg != S_FULL);
    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle.
    assign timeout     = idle_active && (idle_cnt_reg == TIMEOUT_LAST);

    always_ff @(posedge clk_60) begin
        if (rst) begin
            idle_cnt_reg <= 20'd0;
        end else if (!idle_active || timeout) begin
            idle_cnt_reg <= 20'd0;
        end else begin
            idle_cnt_reg <= idle_cnt_reg + 20'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_60) begin
        if (rst) begin
            state_reg <= S_IDLE;
            phase_reg <= 2'd0;
            index_reg <= 14'd0;
            low_reg   <= 16'd0;
            oe_n_reg  <= 1'b1;
            rd_n_reg  <= 1'b1;
            we_reg    <= 1'b0;
            full_reg  <= 1'b0;
            wdata_reg <= 20'd0;
            waddr_reg <= 14'd0;
        end else begin
            we_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (!bus.ftdi_rxf_n) begin
                        state_reg <= S_OE;
                        oe_n_reg  <= 1'b0;
                    end
                end
                // One-cycle bus turnaround before the first read strobe.
                S_OE: begin
                    state_reg <= S_READ;
                    rd_n_reg  <= 1'b0;
                end
                S_READ: begin
                    if (bus.ftdi_rxf_n) begin
                        // Phase and index are kept so reading resumes mid-pixel.
                        state_reg <= S_IDLE;
                        oe_n_reg  <= 1'b1;
                        rd_n_reg  <= 1'b1;
                    end else begin
                        case (phase_reg)
                            2'd0: begin
                                low_reg[7:0] <= bus.ftdi_data;
                                phase_reg    <= 2'd1;
                            end
                            2'd1: begin
                                low_reg[15:8] <= bus.ftdi_data;
                                phase_reg     <= 2'd2;
                            end
                            default: begin
                                we_reg    <= 1'b1;
                                wdata_reg <= {bus.ftdi_data[3:0], low_reg};
                                waddr_reg <= index_reg;
                                phase_reg <= 2'd0;
                                if (index_reg == LAST_INDEX) begin
                                    // Strobes go high now so the next byte
                                    // is not consumed.
                                    full_reg  <= 1'b1;
                                    state_reg <= S_FULL;
                                    oe_n_reg  <= 1'b1;
                                    rd_n_reg  <= 1'b1;
                                end else begin
                                    index_reg <= index_reg + 14'd1;
                                end
                            end
                        endcase
                    end
                end
                S_FULL: begin
                    if (bus.swapped_ftdi) begin
                        full_reg  <= 1'b0;
                        index_reg <= 14'd0;
                        phase_reg <= 2'd0;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
            // Never coincides with an accepted byte or with FULL.
            if (timeout) begin
                phase_reg <= 2'd0;
                index_reg <= 14'd0;
            end
        end
    end

    assign bus.ftdi_oe_n = oe_n_reg;
    assign bus.ftdi_rd_n = rd_n_reg;
    assign bus.we        = we_reg;
    assign bus.wdata     = wdata_reg;
    assign bus.waddr     = waddr_reg;
    assign bus.full_ftdi = full_reg;
endmodule

// File: tb/tb_ftdi_fb_writer.sv
module tb_ftdi_fb_writer;
    localparam int PIXELS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    ftdi_fb_writer_if bus ();

`ifdef FTDI_FB_TIMEOUT_EN
    ftdi_fb_writer #(.PIXELS(PIXELS), .TIMEOUT_CYCLES(8)) dut (
        .clk_60(clk), .rst(rst), .bus(bus)
    );
`else
    ftdi_fb_writer #(.PIXELS(PIXELS)) dut (
        .clk_60(clk), .rst(rst), .bus(bus)
    );
`endif

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [13:0] a;
        logic [19:0] d;
        logic        f;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] stim[$];

    always @(negedge clk) begin
        if (bus.we === 1'b1) wq.push_back('{cyc, bus.waddr, bus.wdata, bus.full_ftdi});
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lets the negedge logger catch a write strobe raised by the last edge.
    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    // Plays the FTDI side: a byte is consumed at each edge where rd_n is low.
    task automatic send_bytes(input bit release_rxf);
        int taken = 0;
        int budget = 0;
        int n = stim.size();
        bit took;
        bus.ftdi_rxf_n = 1'b0;
        while (taken < n && budget < 200) begin
            bus.ftdi_data = stim[taken];
            took = (bus.ftdi_rd_n == 1'b0);
            tick();
            if (took) taken++;
            budget++;
        end
        check("send_budget", 32'(taken), 32'(n));
        stim.delete();
        if (release_rxf) bus.ftdi_rxf_n = 1'b1;
    endtask

    task automatic expect_write(input string tag, input logic [13:0] a,
                                input logic [19:0] d, input logic f, output int wcyc);
        wr_t e;
        wcyc = -1;
        check({tag, "_present"}, 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
            e = wq.pop_front();
            wcyc = e.cyc;
            $display("write %s addr=%0d data=0x%05h full=%0b cyc=%0d", tag, e.a, e.d, e.f, e.cyc);
            check({tag, "_addr"}, 32'(e.a), 32'(a));
            check({tag, "_data"}, 32'(e.d), 32'(d));
            check({tag, "_full"}, 32'(e.f), 32'(f));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_oe_n"}, 32'(bus.ftdi_oe_n), 32'd1);
        check({tag, "_rd_n"}, 32'(bus.ftdi_rd_n), 32'd1);
        check({tag, "_we"}, 32'(bus.we), 32'd0);
        check({tag, "_wdata"}, 32'(bus.wdata), 32'd0);
        check({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
        check({tag, "_full"}, 32'(bus.full_ftdi), 32'd0);
    endtask

    initial begin
        int c0, c1, c2, c3;
        int rd_lows;
        bus.ftdi_data    = 8'h00;
        bus.ftdi_rxf_n   = 1'b1;
        bus.swapped_ftdi = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // Read start timing and first pixel
        bus.ftdi_rxf_n = 1'b0;
        tick();
        check("start_oe_n", 32'(bus.ftdi_oe_n), 32'd0);
        check("start_rd_n_hi", 32'(bus.ftdi_rd_n), 32'd1);
        bus.ftdi_data = 8'h11;
        tick();
        check("start_rd_n_lo", 32'(bus.ftdi_rd_n), 32'd0);
        tick();
        bus.ftdi_data = 8'h22;
        tick();
        bus.ftdi_data = 8'hF3;
        check("lat_we_early", 32'(bus.we), 32'd0);
        tick();
        check("lat_we", 32'(bus.we), 32'd1);
        check("lat_wdata", 32'(bus.wdata), 32'h32211);
        check("lat_waddr", 32'(bus.waddr), 32'd0);
        bus.ftdi_rxf_n = 1'b1;
        drain();
        expect_write("px0", 14'd0, 20'h32211, 1'b0, c0);

        // Pixel 1, then pixel 2 split by an rxf_n gap with an ignored swap
        stim = '{8'h44, 8'h55, 8'h66, 8'hA7, 8'hB8};
        send_bytes(1'b1);
        drain();
        expect_write("px1", 14'd1, 20'h65544, 1'b0, c0);
        bus.swapped_ftdi = 1'b1;
        tick();
        bus.swapped_ftdi = 1'b0;
        tick();
        check("early_swap_full", 32'(bus.full_ftdi), 32'd0);
        stim = '{8'h9C};
        send_bytes(1'b0);
        drain();
        expect_write("px2_split", 14'd2, 20'hCB8A7, 1'b0, c0);

        // Last pixel of the frame, rxf_n kept low
        stim = '{8'h01, 8'h02, 8'hFF};
        send_bytes(1'b0);
        check("f1_end_we", 32'(bus.we), 32'd1);
        check("f1_end_full", 32'(bus.full_ftdi), 32'd1);
        check("f1_end_rd_n", 32'(bus.ftdi_rd_n), 32'd1);
        drain();
        expect_write("px3", 14'd3, 20'hF0201, 1'b1, c0);
        tick();
        tick();
        check("f1_full_hold", 32'(bus.full_ftdi), 32'd1);

        // Swap with rxf_n low: full clears, reading restarts a cycle later
        bus.swapped_ftdi = 1'b1;
        tick();
        bus.swapped_ftdi = 1'b0;
        check("swap_full", 32'(bus.full_ftdi), 32'd0);
        check("swap_oe_n_hi", 32'(bus.ftdi_oe_n), 32'd1);
        tick();
        check("swap_oe_n_lo", 32'(bus.ftdi_oe_n), 32'd0);

        // Full frame streamed continuously
        stim = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60,
                 8'h70, 8'h80, 8'h9A, 8'hBC, 8'hDE, 8'hF5};
        send_bytes(1'b0);
        check("f2_end_full", 32'(bus.full_ftdi), 32'd1);
        check("f2_end_rd_n", 32'(bus.ftdi_rd_n), 32'd1);
        drain();
        expect_write("f2_px0", 14'd0, 20'h02010, 1'b0, c0);
        expect_write("f2_px1", 14'd1, 20'h05040, 1'b0, c1);
        expect_write("f2_px2", 14'd2, 20'hA8070, 1'b0, c2);
        expect_write("f2_px3", 14'd3, 20'h5DEBC, 1'b1, c3);
        check("f2_gap01", 32'(c1 - c0), 32'd3);
        check("f2_gap12", 32'(c2 - c1), 32'd3);
        check("f2_gap23", 32'(c3 - c2), 32'd3);
        rd_lows = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ftdi_rd_n == 1'b0) rd_lows++;
        end
        drain();
        check("full_no_reads", 32'(rd_lows), 32'd0);
        check("full_no_writes", 32'(wq.size()), 32'd0);
        check("full_hold20", 32'(bus.full_ftdi), 32'd1);
        bus.ftdi_rxf_n = 1'b1;
        bus.swapped_ftdi = 1'b1;
        tick();
        bus.swapped_ftdi = 1'b0;
        tick();

        // Reset mid-frame
        stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        send_bytes(1'b1);
        drain();
        expect_write("f3_px0", 14'd0, 20'h63412, 1'b0, c0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        stim = '{8'hAB, 8'hCD, 8'hE1};
        send_bytes(1'b1);
        drain();
        expect_write("post_rst", 14'd0, 20'h1CDAB, 1'b0, c0);

`ifdef FTDI_FB_TIMEOUT_EN
        // Idle timeout discards the partial frame
        stim = '{8'h33, 8'h44};
        send_bytes(1'b1);
        for (int i = 0; i < 10; i++) tick();
        stim = '{8'h21, 8'h43, 8'h65};
        send_bytes(1'b1);
        drain();
        expect_write("timeout", 14'd0, 20'h54321, 1'b0, c0);
`endif

        tick();
        drain();
        check("no_stray_writes", 32'(wq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
